commit_trace_buffer: RTL and testbench



---
 rtl/ariane_pkg.sv | 41 ++++
 rtl/commit_trace_fifo.sv | 63 ++++++
 rtl/commit_trace_buffer.sv | 116 +++++++++++
 tb/tb_commit_trace_buffer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// ariane_pkg: shared types for the commit trace path.
//   scoreboard_entry_t - the subset of a commit-port entry the tracer records
//   exception_t        - exception taken at commit
//   commit_trace_t     - one record streamed to the debug/trace sink
//   sat_add_drop       - saturating add used by the drop counter
package ariane_pkg;
  localparam int unsigned XLEN         = 64;
  localparam int unsigned VLEN         = 64;
  localparam int unsigned TRACE_DROP_W = 16;

  typedef struct packed {
    logic [VLEN-1:0] pc;
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
  } scoreboard_entry_t;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [VLEN-1:0] pc;
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
    logic [31:0]     seq;
    logic            is_exc;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
  } commit_trace_t;

  function automatic logic [TRACE_DROP_W-1:0] sat_add_drop(
    input logic [TRACE_DROP_W-1:0] a,
    input logic [TRACE_DROP_W-1:0] b
  );
    logic [TRACE_DROP_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[TRACE_DROP_W] ? '1 : s[TRACE_DROP_W-1:0];
  endfunction
endpackage

// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo: multi-write (0..NR_W per cycle) / single-read FIFO.
//   clk_i, rst_i  clock, async active-high reset
//   flush_i       synchronous empty; overrides writes and pop
//   wr_cnt_i      number of records written this cycle (caller checks space)
//   wr_data_i     records, slot 0 written first
//   pop_i         sink handshake; ignored when empty
//   rd_data_o     head record, read combinationally at rd_ptr
//   count_o       occupancy (DEPTH means full)
module commit_trace_fifo import ariane_pkg::*; #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned NR_W  = 2,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(NR_W + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic [CW-1:0]            wr_cnt_i,
  input  commit_trace_t [NR_W-1:0] wr_data_i,
  input  logic                     pop_i,
  output commit_trace_t            rd_data_o,
  output logic [AW:0]              count_o
);
  commit_trace_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_pop;

  assign do_pop = pop_i && (cnt_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_cnt_i);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + (AW+1)'(wr_cnt_i) - (AW+1)'(do_pop);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the top masks the head record while empty.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NR_W; i++) begin
      if (!flush_i && (CW'(i) < wr_cnt_i)) mem_q[wr_ptr_q + AW'(i)] <= wr_data_i[i];
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = cnt_q;
endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: passive observer of the commit stage.
//   clk_i, rst_i          clock, async active-high reset
//   en_i                  trace enable; gates enqueue and drop counting
//   flush_i               empty the FIFO (counters keep their values)
//   clear_i               clear overflow_o / dropped_o
//   commit_instr_i/ack_i  commit ports (acks contiguous from port 0)
//   exception_i           exception taken at commit
//   trace_valid_o/ready_i record handshake to the sink, trace_o head record
//   instret_o             retired-instruction count
//   overflow_o, dropped_o sticky loss flag and saturating drop count
// Never back-pressures commit: a group that does not fit is dropped whole.
module commit_trace_buffer import ariane_pkg::*; #(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DEPTH           = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                en_i,
  input  logic                                flush_i,
  input  logic                                clear_i,
  input  scoreboard_entry_t [NR_COMMIT_PORTS-1:0] commit_instr_i,
  input  logic [NR_COMMIT_PORTS-1:0]          commit_ack_i,
  input  exception_t                          exception_i,
  output logic                                trace_valid_o,
  input  logic                                trace_ready_i,
  output commit_trace_t                       trace_o,
  output logic [63:0]                         instret_o,
  output logic                                overflow_o,
  output logic [TRACE_DROP_W-1:0]             dropped_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(NR_COMMIT_PORTS + 1);

  logic [CW-1:0]                       k, g, wr_cnt;
  commit_trace_t [NR_COMMIT_PORTS-1:0] grp;
  commit_trace_t                       head;
  logic [AW:0]                         fifo_cnt, free;
  logic                                want, fits, push, drop;
  logic [63:0]                         instret_q, instret_d;
  logic [TRACE_DROP_W-1:0]             dropped_q, dropped_d;
  logic                                overflow_q, overflow_d;

  // Group formation: an exception yields a single record and masks the acks.
  always_comb begin
    k   = '0;
    grp = '0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      k = k + CW'(commit_ack_i[i]);
      grp[i].pc     = commit_instr_i[i].pc;
      grp[i].rd     = commit_instr_i[i].rd;
      grp[i].result = commit_instr_i[i].result;
      grp[i].seq    = instret_q[31:0] + 32'(i);
    end
    g = k;
    if (exception_i.valid) begin
      grp[0]        = '0;
      grp[0].pc     = commit_instr_i[0].pc;
      grp[0].seq    = instret_q[31:0];
      grp[0].is_exc = 1'b1;
      grp[0].cause  = exception_i.cause;
      grp[0].tval   = exception_i.tval;
      g             = CW'(1);
    end
  end

  // Space is judged against the occupancy before this cycle's dequeue.
  assign free   = (AW+1)'(DEPTH) - fifo_cnt;
  assign fits   = (AW+1)'(g) <= free;
  assign want   = en_i && (g != '0) && !flush_i;
  assign push   = want && fits;
  assign drop   = want && !fits;
  assign wr_cnt = push ? g : '0;

  always_comb begin
    instret_d  = instret_q + (exception_i.valid ? 64'd0 : 64'(k));
    dropped_d  = clear_i ? '0 : dropped_q;
    overflow_d = clear_i ? 1'b0 : overflow_q;
    // A drop in the same cycle as clear_i still registers.
    if (drop) begin
      dropped_d  = sat_add_drop(dropped_d, TRACE_DROP_W'(g));
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instret_q  <= '0;
      dropped_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      instret_q  <= instret_d;
      dropped_q  <= dropped_d;
      overflow_q <= overflow_d;
    end
  end

  commit_trace_fifo #(
    .DEPTH (DEPTH),
    .NR_W  (NR_COMMIT_PORTS)
  ) i_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (flush_i),
    .wr_cnt_i  (wr_cnt),
    .wr_data_i (grp),
    .pop_i     (trace_ready_i),
    .rd_data_o (head),
    .count_o   (fifo_cnt)
  );

  assign trace_valid_o = (fifo_cnt != '0);
  assign trace_o       = trace_valid_o ? head : '0;
  assign instret_o     = instret_q;
  assign overflow_o    = overflow_q;
  assign dropped_o     = dropped_q;
endmodule

// File: tb/tb_commit_trace_buffer.sv
module tb_commit_trace_buffer;
  import ariane_pkg::*;

  logic                    clk_i = 1'b0;
  logic                    rst_i = 1'b0;
  logic                    en_i, flush_i, clear_i, trace_ready_i;
  scoreboard_entry_t [1:0] commit_instr_i;
  logic [1:0]              commit_ack_i;
  exception_t              exception_i;
  logic                    trace_valid_o, overflow_o;
  commit_trace_t           trace_o;
  logic [63:0]             instret_o;
  logic [15:0]             dropped_o;

  commit_trace_buffer #(.NR_COMMIT_PORTS(2), .DEPTH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .flush_i(flush_i), .clear_i(clear_i),
    .commit_instr_i(commit_instr_i), .commit_ack_i(commit_ack_i), .exception_i(exception_i),
    .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i), .trace_o(trace_o),
    .instret_o(instret_o), .overflow_o(overflow_o), .dropped_o(dropped_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: a queue of records plus plain counters.
  commit_trace_t exp_q[$];
  commit_trace_t pend_q[$];
  logic          pend_v = 1'b0, pend_flush = 1'b0;
  logic [63:0]   m_instret = '0, n_instret;
  logic [15:0]   m_drop = '0, n_drop;
  logic          m_ovf = 1'b0, n_ovf;
  int            passed = 0, total = 0;

  // Payload holders set by the stimulus before each step.
  logic [63:0] d_pc [2];
  logic [4:0]  d_rd [2];
  logic [63:0] d_res [2];
  logic [63:0] d_cause, d_tval;

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one cycle of inputs just after a rising edge and predict its effect.
  task automatic step(input logic [1:0] ack, input logic exc, input logic en,
                      input logic fl, input logic clr, input logic rdy);
    commit_trace_t recs[$];
    commit_trace_t r;
    int unsigned g, k;
    @(posedge clk_i); #1;
    for (int i = 0; i < 2; i++) begin
      commit_instr_i[i].pc     = d_pc[i];
      commit_instr_i[i].rd     = d_rd[i];
      commit_instr_i[i].result = d_res[i];
    end
    commit_ack_i = ack; exception_i.valid = exc;
    exception_i.cause = d_cause; exception_i.tval = d_tval;
    en_i = en; flush_i = fl; clear_i = clr; trace_ready_i = rdy;

    k = $countones(ack);
    if (exc) begin
      r = '0; r.pc = d_pc[0]; r.seq = m_instret[31:0]; r.is_exc = 1'b1;
      r.cause = d_cause; r.tval = d_tval;
      recs.push_back(r);
    end else begin
      for (int i = 0; i < int'(k); i++) begin
        r = '0; r.pc = d_pc[i]; r.rd = d_rd[i]; r.result = d_res[i];
        r.seq = m_instret[31:0] + i;
        recs.push_back(r);
      end
    end
    g = recs.size();
    n_instret = m_instret + (exc ? 64'd0 : 64'(k));
    n_drop = clr ? 16'd0 : m_drop;
    n_ovf  = clr ? 1'b0 : m_ovf;
    pend_q.delete();
    if (en && g > 0 && !fl) begin
      if (g <= 8 - exp_q.size()) pend_q = recs;
      else begin
        n_drop = (int'(n_drop) + g > 65535) ? 16'hFFFF : n_drop + 16'(g);
        n_ovf  = 1'b1;
      end
    end
    pend_flush = fl;
    pend_v     = 1'b1;
  endtask

  task automatic idle(input logic rdy);
    step(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, rdy);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    chk("rst_valid", trace_valid_o, 1'b0);
    chk("rst_trace", trace_o, '0);
    chk("rst_instret", instret_o, 64'd0);
    chk("rst_overflow", overflow_o, 1'b0);
    chk("rst_dropped", dropped_o, 16'd0);
    exp_q.delete(); pend_q.delete(); pend_v = 1'b0;
    m_instret = '0; m_drop = '0; m_ovf = 1'b0;
    commit_ack_i = '0; exception_i = '0; en_i = 1'b0; flush_i = 1'b0;
    clear_i = 1'b0; trace_ready_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  // Apply the predicted edge effect to the model.
  always @(posedge clk_i) begin
    if (!rst_i && pend_v) begin
      if (pend_flush) exp_q.delete();
      else foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
      m_instret = n_instret; m_drop = n_drop; m_ovf = n_ovf;
      pend_v = 1'b0;
    end
  end

  // Monitor: compares whatever the DUT presents against the scoreboard.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      assert (commit_ack_i != 2'b10) else $error("illegal non-contiguous ack driven");
      chk("valid", trace_valid_o, exp_q.size() != 0);
      if (trace_valid_o && exp_q.size() != 0) begin
        chk("record", trace_o, exp_q[0]);
        if (trace_ready_i) void'(exp_q.pop_front());
      end
      chk("instret", instret_o, m_instret);
      chk("dropped", dropped_o, m_drop);
      chk("overflow", overflow_o, m_ovf);
    end
  end

  task automatic rand_payload();
    for (int i = 0; i < 2; i++) begin
      d_pc[i] = {$urandom, $urandom}; d_rd[i] = 5'($urandom); d_res[i] = {$urandom, $urandom};
    end
    d_cause = 64'($urandom_range(0, 15)); d_tval = {$urandom, $urandom};
  endtask

  initial begin
    rand_payload();
    commit_instr_i = '0; commit_ack_i = '0; exception_i = '0;
    en_i = 1'b0; flush_i = 1'b0; clear_i = 1'b0; trace_ready_i = 1'b0;
    #2;
    do_reset();

    // Single commit
    d_pc[0] = 64'h8000_0000; d_rd[0] = 5'd5; d_res[0] = 64'h2A;
    step(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    chk("single_valid", trace_valid_o, 1'b1);
    chk("single_pc", trace_o.pc, 64'h8000_0000);
    chk("single_seq", trace_o.seq, 32'd0);
    chk("single_result", trace_o.result, 64'h2A);
    chk("single_instret", instret_o, 64'd1);
    do_reset();

    // Dual commit, port order
    d_pc[0] = 64'h100; d_pc[1] = 64'h104;
    step(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    chk("dual_pc0", trace_o.pc, 64'h100);
    chk("dual_seq0", trace_o.seq, 32'd0);
    idle(1'b1);
    chk("dual_pc1", trace_o.pc, 64'h104);
    chk("dual_seq1", trace_o.seq, 32'd1);
    chk("dual_instret", instret_o, 64'd2);
    idle(1'b1);
    chk("dual_empty", trace_valid_o, 1'b0);
    do_reset();

    // Exception record
    d_cause = 64'd2; d_tval = 64'hDEAD;
    step(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("exc_is_exc", trace_o.is_exc, 1'b1);
    chk("exc_cause", trace_o.cause, 64'd2);
    chk("exc_tval", trace_o.tval, 64'hDEAD);
    chk("exc_instret", instret_o, 64'd0);
    do_reset();

    // Overflow then clear
    for (int i = 0; i < 5; i++) begin
      rand_payload();
      step(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    idle(1'b0);
    chk("ovf_dropped", dropped_o, 16'd2);
    chk("ovf_flag", overflow_o, 1'b1);
    chk("ovf_instret", instret_o, 64'd10);
    step(2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    chk("clr_dropped", dropped_o, 16'd0);
    chk("clr_flag", overflow_o, 1'b0);
    for (int i = 0; i < 9; i++) idle(1'b1);
    chk("ovf_drained", trace_valid_o, 1'b0);
    do_reset();

    // Seven occupied, dual group with same-cycle dequeue is still dropped
    for (int i = 0; i < 4; i++) begin
      rand_payload();
      step(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    idle(1'b1);
    rand_payload();
    step(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    chk("bnd_dropped", dropped_o, 16'd2);
    chk("bnd_flag", overflow_o, 1'b1);
    for (int i = 0; i < 8; i++) idle(1'b1);
    chk("bnd_drained", trace_valid_o, 1'b0);
    do_reset();

    // Flush with a group in the same cycle
    step(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    chk("flush_valid", trace_valid_o, 1'b0);
    chk("flush_dropped", dropped_o, 16'd0);
    chk("flush_instret", instret_o, 64'd4);

    // Reset in the middle of a transfer
    step(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    chk("mid_valid", trace_valid_o, 1'b1);
    do_reset();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [1:0] ack;
      rand_payload();
      case ($urandom_range(0, 2))
        0: ack = 2'b00;
        1: ack = 2'b01;
        default: ack = 2'b11;
      endcase
      step(ack, ($urandom % 10) == 0, ($urandom % 8) != 0, ($urandom % 30) == 0,
           ($urandom % 20) == 0, 1'($urandom));
    end
    for (int i = 0; i < 12; i++) idle(1'b1);
    chk("final_drained", trace_valid_o, 1'b0);

    @(posedge clk_i); #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
